reg_file_bank: RTL and testbench

Integer register file: the storage side of the register-file interface. It serves two combinational source-register read ports (rs1, rs2) and one synchronous destination-register write port (rd) for the core controller. A post-reset clear sweep zeroes storage one entry per cycle, so the array can map to distributed RAM with no bulk reset. A handshaked dump stream serialises all registers out for debug and test.

---
 rtl/reg_file_bank_pkg.sv | 12 +
 rtl/reg_file_bank_if.sv | 35 +++
 rtl/reg_file_mem.sv | 31 +++
 rtl/reg_file_bank.sv | 113 +++++++++++
 tb/tb_reg_file_bank.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_bank_pkg.sv
// Shared parameters and types for the integer register file.
//   XLEN           : default data width
//   REG_ADDR_WIDTH : default register address width
//   NUM_REGS       : number of architectural registers (x0 included)
//   rf_state_e     : register-file controller states
package pkg_parameters;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {RF_CLEAR, RF_RUN, RF_DUMP} rf_state_e;
endpackage

// File: rtl/reg_file_bank_if.sv
// Register-file bus between the core controller and the storage bank.
//   rs1/rs2 : combinational read ports (addr in, data out)
//   rd      : synchronous write port (web/addr/data)
//   rf_ready: bank accepts writes (RUN only)
//   dump_*  : valid/ready stream serialising every register out
// Modports: rf (storage side), ctrl (controller / debug side).
interface reg_file_bank_if #(
  parameter int XLEN       = pkg_parameters::XLEN,
  parameter int ADDR_WIDTH = pkg_parameters::REG_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [XLEN-1:0]       rs2_data;
  logic                  rd_web;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic                  rf_ready;
  logic                  dump_req;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ADDR_WIDTH-1:0] dump_idx;
  logic [XLEN-1:0]       dump_data;
  logic                  dump_last;

  modport rf (
    input  rs1_addr, rs2_addr, rd_web, rd_addr, rd_data, dump_req, dump_ready,
    output rs1_data, rs2_data, rf_ready, dump_valid, dump_idx, dump_data, dump_last
  );

  modport ctrl (
    output rs1_addr, rs2_addr, rd_web, rd_addr, rd_data, dump_req, dump_ready,
    input  rs1_data, rs2_data, rf_ready, dump_valid, dump_idx, dump_data, dump_last
  );
endinterface

// File: rtl/reg_file_mem.sv
// Register storage x1..x(NUM_REGS-1); x0 has no backing entry.
//   we/waddr/wdata       : write port, commits on rising clk edge
//   raddr1/2, raddr_dump : asynchronous reads, address 0 reads as 0
// No reset: contents are zeroed by the bank's clear sweep.
module reg_file_mem #(
  parameter int XLEN       = pkg_parameters::XLEN,
  parameter int ADDR_WIDTH = pkg_parameters::REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [ADDR_WIDTH-1:0] raddr_dump,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2,
  output logic [XLEN-1:0]       rdata_dump
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [XLEN-1:0] mem [1:NREGS-1];

  always_ff @(posedge clk) begin
    if (we && waddr != '0) mem[waddr] <= wdata;
  end

  assign rdata1     = (raddr1     == '0) ? '0 : mem[raddr1];
  assign rdata2     = (raddr2     == '0) ? '0 : mem[raddr2];
  assign rdata_dump = (raddr_dump == '0) ? '0 : mem[raddr_dump];
endmodule

// File: rtl/reg_file_bank.sv
// Integer register file bank: FSM (CLEAR/RUN/DUMP), post-reset clear sweep,
// write-to-read bypass and the debug dump sequencer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf-side modport of reg_file_bank_if
module reg_file_bank
  import pkg_parameters::*;
#(
  parameter int XLEN       = pkg_parameters::XLEN,
  parameter int ADDR_WIDTH = pkg_parameters::REG_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_bank_if.rf    bus
);
  localparam int                    NREGS    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NREGS - 1);

  rf_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx, dump_idx;
  logic                  dump_valid, dump_fire, dump_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [XLEN-1:0]       mem_wdata, rd1, rd2, rdd;

  assign dump_fire = dump_valid && bus.dump_ready;
  assign dump_last = dump_valid && (dump_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= RF_CLEAR;
    else     state <= state_nxt;
  end

  // Next state and the single storage write port: the sweep owns it in
  // CLEAR, the controller in RUN, nobody in DUMP (keeps dump_data stable).
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = bus.rd_addr;
    mem_wdata = bus.rd_data;
    case (state)
      RF_CLEAR: begin
        mem_we    = !rst;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        if (clr_idx == LAST_IDX) state_nxt = RF_RUN;
      end
      RF_RUN: begin
        mem_we = bus.rd_web && !rst;
        if (bus.dump_req) state_nxt = RF_DUMP;
      end
      RF_DUMP: begin
        if (dump_fire && dump_last) state_nxt = RF_RUN;
      end
      default: state_nxt = RF_CLEAR;
    endcase
  end

  // Sweep starts at x1: x0 has no storage. dump_idx wraps back to 0 after
  // the last beat so the next dump needs no extra bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx    <= ADDR_WIDTH'(1);
      dump_idx   <= '0;
      dump_valid <= 1'b0;
    end else begin
      if (state == RF_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (state == RF_RUN && bus.dump_req) begin
        dump_valid <= 1'b1;
        dump_idx   <= '0;
      end else if (state == RF_DUMP && dump_fire) begin
        dump_idx <= dump_idx + 1'b1;
        if (dump_last) dump_valid <= 1'b0;
      end
    end
  end

  reg_file_mem #(.XLEN(XLEN), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk        (clk),
    .we         (mem_we),
    .waddr      (mem_waddr),
    .wdata      (mem_wdata),
    .raddr1     (bus.rs1_addr),
    .raddr2     (bus.rs2_addr),
    .raddr_dump (dump_idx),
    .rdata1     (rd1),
    .rdata2     (rd2),
    .rdata_dump (rdd)
  );

  // Reads are 0 while clearing; bypass applies only in RUN, where writes commit.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (state == RF_RUN) begin
      bus.rs1_data = rd1;
      bus.rs2_data = rd2;
      if (BYPASS != 0 && bus.rd_web) begin
        if (bus.rd_addr == bus.rs1_addr && bus.rs1_addr != '0) bus.rs1_data = bus.rd_data;
        if (bus.rd_addr == bus.rs2_addr && bus.rs2_addr != '0) bus.rs2_data = bus.rd_data;
      end
    end else if (state == RF_DUMP) begin
      bus.rs1_data = rd1;
      bus.rs2_data = rd2;
    end
  end

  assign bus.rf_ready   = (state == RF_RUN);
  assign bus.dump_valid = dump_valid;
  assign bus.dump_idx   = dump_idx;
  assign bus.dump_data  = dump_valid ? rdd : '0;
  assign bus.dump_last  = dump_last;
endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench: two banks (BYPASS=1 and BYPASS=0) share one stimulus;
// expectations come from a plain register-array model.
module tb_reg_file_bank;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [XL-1:0] rd_data;
  logic          rd_web, dump_req, dump_ready;

  reg_file_bank_if #(.XLEN(XL), .ADDR_WIDTH(AW)) b0 ();
  reg_file_bank_if #(.XLEN(XL), .ADDR_WIDTH(AW)) b1 ();

  assign b0.rs1_addr = rs1_addr;  assign b1.rs1_addr = rs1_addr;
  assign b0.rs2_addr = rs2_addr;  assign b1.rs2_addr = rs2_addr;
  assign b0.rd_web   = rd_web;    assign b1.rd_web   = rd_web;
  assign b0.rd_addr  = rd_addr;   assign b1.rd_addr  = rd_addr;
  assign b0.rd_data  = rd_data;   assign b1.rd_data  = rd_data;
  assign b0.dump_req = dump_req;  assign b1.dump_req = dump_req;
  assign b0.dump_ready = dump_ready;  assign b1.dump_ready = dump_ready;

  // index 0: no bypass, index 1: bypass
  logic [XL-1:0] o_rs1 [2];
  logic [XL-1:0] o_rs2 [2];
  logic [XL-1:0] o_dd  [2];
  logic [AW-1:0] o_di  [2];
  logic          o_rdy [2];
  logic          o_dv  [2];
  logic          o_dl  [2];
  assign o_rs1[0] = b0.rs1_data;   assign o_rs1[1] = b1.rs1_data;
  assign o_rs2[0] = b0.rs2_data;   assign o_rs2[1] = b1.rs2_data;
  assign o_dd[0]  = b0.dump_data;  assign o_dd[1]  = b1.dump_data;
  assign o_di[0]  = b0.dump_idx;   assign o_di[1]  = b1.dump_idx;
  assign o_rdy[0] = b0.rf_ready;   assign o_rdy[1] = b1.rf_ready;
  assign o_dv[0]  = b0.dump_valid; assign o_dv[1]  = b1.dump_valid;
  assign o_dl[0]  = b0.dump_last;  assign o_dl[1]  = b1.dump_last;

  reg_file_bank #(.XLEN(XL), .ADDR_WIDTH(AW), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  reg_file_bank #(.XLEN(XL), .ADDR_WIDTH(AW), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int passed = 0;
  int total  = 0;
  logic [XL-1:0] m [NR];  // reference register contents, m[0] stays 0

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a clear sweep with rst already low; expects NR-1 edges to RUN.
  task automatic sweep(string tag);
    int n = 0;
    rs1_addr = 5'd5;
    while (o_rdy[0] !== 1'b1 && n < 100) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s_clr_read_d%0d", tag, d), o_rs1[d], 0);
        chk($sformatf("%s_clr_dv_d%0d", tag, d), o_dv[d], 0);
      end
      tick();
      n++;
    end
    rd_web = 1'b0; dump_req = 1'b0;
    chk({tag, "_len"}, n, NR - 1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ready_d%0d", tag, d), o_rdy[d], 1);
      chk($sformatf("%s_dv_after_d%0d", tag, d), o_dv[d], 0);
    end
    for (int i = 0; i < NR; i++) m[i] = '0;
  endtask

  task automatic wr(int a, logic [XL-1:0] v);
    rd_web = 1'b1; rd_addr = AW'(a); rd_data = v;
    tick();
    if (a != 0) m[a] = v;
    rd_web = 1'b0;
  endtask

  initial begin
    int beat, cyc, a, b;
    logic [XL-1:0] exp1, exp2;

    // reset with a write and a dump request held through CLEAR
    rst = 1'b1; rd_web = 1'b1; rd_addr = 5'd5; rd_data = 32'hFFFF_FFFF;
    rs1_addr = 5'd5; rs2_addr = 5'd0; dump_req = 1'b1; dump_ready = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d), o_rdy[d], 0);
      chk($sformatf("rst_dv_d%0d", d), o_dv[d], 0);
      chk($sformatf("rst_didx_d%0d", d), o_di[d], 0);
      chk($sformatf("rst_ddata_d%0d", d), o_dd[d], 0);
      chk($sformatf("rst_dlast_d%0d", d), o_dl[d], 0);
      chk($sformatf("rst_rs1_d%0d", d), o_rs1[d], 0);
    end
    rst = 1'b0;
    sweep("sweep1");
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("x5_zero_d%0d", d), o_rs1[d], 0);

    // write then read
    wr(7, 32'hDEAD_BEEF);
    rs1_addr = 5'd7; rs2_addr = 5'd0; #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("x7_rd_d%0d", d), o_rs1[d], 32'hDEAD_BEEF);
      chk($sformatf("x0_rs2_d%0d", d), o_rs2[d], 0);
    end

    // same-cycle bypass
    rd_web = 1'b1; rd_addr = 5'd3; rd_data = 32'h1234; rs1_addr = 5'd3; #1;
    chk("bypass_on", o_rs1[1], 32'h1234);
    chk("bypass_off", o_rs1[0], 0);
    tick(); m[3] = 32'h1234; rd_web = 1'b0; #1;
    for (int d = 0; d < 2; d++) chk($sformatf("x3_after_d%0d", d), o_rs1[d], 32'h1234);

    // x0 never stored, never bypassed
    rd_web = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    for (int d = 0; d < 2; d++) chk($sformatf("x0_bypass_d%0d", d), o_rs1[d], 0);
    tick(); rd_web = 1'b0; #1;
    for (int d = 0; d < 2; d++) chk($sformatf("x0_after_d%0d", d), o_rs2[d], 0);

    // random read/write traffic against the model
    for (int k = 0; k < 60; k++) begin
      rd_web = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 7));
      rd_data = $urandom;
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = (k % 4 == 0) ? rd_addr : AW'($urandom_range(0, 7));
      #1;
      exp1 = (rd_web && rd_addr == rs1_addr && rs1_addr != 0) ? rd_data : m[rs1_addr];
      exp2 = (rd_web && rd_addr == rs2_addr && rs2_addr != 0) ? rd_data : m[rs2_addr];
      chk($sformatf("rnd%0d_rs1_byp", k), o_rs1[1], exp1);
      chk($sformatf("rnd%0d_rs2_byp", k), o_rs2[1], exp2);
      chk($sformatf("rnd%0d_rs1_nob", k), o_rs1[0], m[rs1_addr]);
      chk($sformatf("rnd%0d_rs2_nob", k), o_rs2[0], m[rs2_addr]);
      tick();
      if (rd_web && rd_addr != 0) m[rd_addr] = rd_data;
    end
    rd_web = 1'b0;

    // dump with backpressure; x31 is written in the dump_req cycle
    for (int i = 1; i < NR - 1; i++) wr(i, XL'(i * 16));
    wr(31, 32'h0);
    rd_web = 1'b1; rd_addr = 5'd31; rd_data = 32'h1F0; dump_req = 1'b1;
    tick(); m[31] = 32'h1F0;
    dump_req = 1'b0; rd_web = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dump_enter_ready_d%0d", d), o_rdy[d], 0);
      chk($sformatf("dump_enter_dv_d%0d", d), o_dv[d], 1);
    end
    beat = 0; cyc = 0;
    while (beat < NR && cyc < 200) begin
      dump_ready = (cyc % 2 == 0);
      rd_web = 1'b1; rd_addr = AW'($urandom_range(1, NR - 1)); rd_data = $urandom;
      rs1_addr = rd_addr; dump_req = 1'($urandom_range(0, 1));
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dump_c%0d_dv_d%0d", cyc, d), o_dv[d], 1);
        chk($sformatf("dump_c%0d_idx_d%0d", cyc, d), o_di[d], beat);
        chk($sformatf("dump_c%0d_data_d%0d", cyc, d), o_dd[d], m[beat]);
        chk($sformatf("dump_c%0d_last_d%0d", cyc, d), o_dl[d], beat == NR - 1);
        chk($sformatf("dump_c%0d_rd_d%0d", cyc, d), o_rs1[d], m[rs1_addr]);
      end
      if (dump_ready) beat++;
      tick();
      cyc++;
    end
    rd_web = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    chk("dump_beats", beat, NR);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dump_exit_dv_d%0d", d), o_dv[d], 0);
      chk($sformatf("dump_exit_ready_d%0d", d), o_rdy[d], 1);
    end
    for (int i = 0; i < NR; i += 5) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NR - 1 - i); #1;
      chk($sformatf("post_dump_x%0d", i), o_rs1[0], m[i]);
      chk($sformatf("post_dump_x%0d", NR - 1 - i), o_rs2[1], m[NR - 1 - i]);
    end

    // reset in the middle of a dump
    dump_req = 1'b1; tick(); dump_req = 1'b0; dump_ready = 1'b1;
    repeat (10) tick();
    for (int d = 0; d < 2; d++) chk($sformatf("mid_idx_d%0d", d), o_di[d], 10);
    rst = 1'b1; dump_ready = 1'b0; tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_rst_dv_d%0d", d), o_dv[d], 0);
      chk($sformatf("mid_rst_ready_d%0d", d), o_rdy[d], 0);
    end
    rst = 1'b0;
    sweep("sweep2");
    for (int i = 1; i < NR; i++) begin
      a = i; b = NR - i;
      rs1_addr = AW'(a); rs2_addr = AW'(b); #1;
      chk($sformatf("cleared_x%0d_d0", a), o_rs1[0], 0);
      chk($sformatf("cleared_x%0d_d1", b), o_rs2[1], 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
